// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out shifter, MSB first, DIV clocks per bit
module piso_serializer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             serial_bit,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);
  localparam int BW = $clog2(WIDTH);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("piso_serializer: WIDTH must be 2..32");
  end
  if (DIV < 1 || DIV > 255) begin : g_bad_div
    $error("piso_serializer: DIV must be 1..255");
  end
  logic [1:0]       state_q;
  state_t           state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             ser_q, ser_d;
  // registers; the unreachable code 2'd3 falls back to IDLE through the default arm below
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      ser_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      ser_q   <= ser_d;
    end
  end
  // next state: capture on load in IDLE, step bits every DIV cycles in SHIFT, one DONE cycle
  always_comb begin
    state_d = IDLE;
    shreg_d = shreg_q;
    div_d   = div_q;
    bit_d   = bit_q;
    ser_d   = 1'b0;
    case (state_q)
      IDLE: if (load) begin
        shreg_d = data_in;
        ser_d   = data_in[WIDTH-1];
        div_d   = '0;
        bit_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        state_d = SHIFT;
        ser_d   = ser_q;
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = DONE;
            ser_d   = 1'b0;
          end else begin
            shreg_d = shreg_q << 1;
            ser_d   = shreg_q[WIDTH-2];
            bit_d   = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign state      = state_q;
  assign serial_bit = ser_q;
  assign ready      = state_q == IDLE;
  assign busy       = state_q == SHIFT;
  assign done       = state_q == DONE;
  assign bit_valid  = state_q == SHIFT && div_q == DIV_LAST;
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed checks of the serializer at DIV=4 and DIV=1
module tb_piso_serializer;
  logic       clk, rst;
  logic [7:0] data_in, data1;
  logic       load, load1;
  logic       ready, serial_bit, bit_valid, busy, done;
  logic       ready1, serial1, bv1, busy1, done1;
  logic [1:0] state, state1;
  int errors = 0;
  int checks = 0;
  piso_serializer #(.WIDTH(8), .DIV(4)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load), .ready(ready),
    .serial_bit(serial_bit), .bit_valid(bit_valid), .busy(busy), .done(done), .state(state)
  );
  piso_serializer #(.WIDTH(8), .DIV(1)) dut1 (
    .clk(clk), .rst(rst), .data_in(data1), .load(load1), .ready(ready1),
    .serial_bit(serial1), .bit_valid(bv1), .busy(busy1), .done(done1), .state(state1)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  logic       det_clr;
  logic [2:0] hist;
  int         bits_seen;
  logic [15:0] det_mask;
  // downstream overlapping 101 detector fed on each bit strobe
  always @(posedge clk) begin
    if (rst || det_clr) begin
      hist <= 3'b000;
      bits_seen <= 0;
    end else if (bit_valid) begin
      hist <= {hist[1:0], serial_bit};
      bits_seen <= bits_seen + 1;
    end
  end
  // remember after which bit count the detector output was high
  always @(negedge clk) begin
    if (det_clr) det_mask <= '0;
    else if (hist == 3'b101) det_mask <= det_mask | (16'd1 << bits_seen);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run_word(input logic [7:0] w, input logic [7:0] noise, input bit keep, input string tag);
    int bad, vcnt;
    bit eb;
    bad = 0;
    vcnt = 0;
    @(posedge clk);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      eb = w[7 - k / 4];
      if (serial_bit !== eb || busy !== 1'b1 || done !== 1'b0 || ready !== 1'b0 ||
          bit_valid !== (k % 4 == 3)) bad++;
      if (bit_valid === 1'b1) vcnt++;
      load = keep && k < 31;
      data_in = noise;
    end
    chk({tag, "_stream"}, bad, 0);
    chk({tag, "_valid_cnt"}, vcnt, 8);
    @(negedge clk);
    chk({tag, "_done"}, {done, busy, ready, serial_bit, 2'b00, state}, {4'b1000, 4'h2});
    @(negedge clk);
    chk({tag, "_ready"}, {done, busy, ready, serial_bit, 2'b00, state}, {4'b0010, 4'h0});
  endtask
  initial begin
    int cnt;
    rst = 1'b1;
    load = 1'b0;
    load1 = 1'b0;
    data_in = '0;
    data1 = '0;
    det_clr = 1'b1;
    #3;
    chk("reset_state", state, 2'd0);
    chk("reset_flags", {ready, busy, done, bit_valid, serial_bit}, 5'b10000);
    chk("reset_flags1", {ready1, busy1, done1, bv1, serial1}, 5'b10000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_hold", {state, serial_bit, ready}, {2'd0, 1'b0, 1'b1});
    data_in = 8'hA5;
    load = 1'b1;
    run_word(8'hA5, 8'hA5, 1'b0, "a5");
    data_in = 8'hA5;
    load = 1'b1;
    run_word(8'hA5, 8'hC3, 1'b1, "a5_c3");
    @(negedge clk);
    chk("no_second_done", {done, state}, {1'b0, 2'd0});
    data_in = 8'hA5;
    load = 1'b1;
    @(posedge clk);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      load = 1'b0;
      if (bit_valid === 1'b1) cnt++;
    end
    chk("pre_rst_valid", {cnt[7:0], bit_valid, state}, {8'd3, 1'b1, 2'd1});
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {serial_bit, state, ready, busy, done}, {1'b0, 2'd0, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1 || state !== 2'd0) cnt++;
    end
    chk("aborted_quiet", cnt, 0);
    data_in = 8'h0F;
    load = 1'b1;
    run_word(8'h0F, 8'h0F, 1'b0, "0f");
    @(negedge clk);
    det_clr = 1'b0;
    data_in = 8'hA8;
    load = 1'b1;
    run_word(8'hA8, 8'hA8, 1'b0, "a8");
    chk("det_101", det_mask, 16'h0028);
    data1 = 8'hFF;
    load1 = 1'b1;
    @(posedge clk);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      data1 = 8'h00;
      if (serial1 !== 1'b1 || busy1 !== 1'b1 || bv1 !== 1'b1) cnt++;
    end
    chk("div1_ones", cnt, 0);
    @(negedge clk);
    chk("div1_done_a", {done1, serial1, state1}, {1'b1, 1'b0, 2'd2});
    @(negedge clk);
    chk("div1_idle", {ready1, serial1, busy1, bv1}, 4'b1000);
    @(posedge clk);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (serial1 !== 1'b0 || busy1 !== 1'b1 || bv1 !== 1'b1) cnt++;
    end
    chk("div1_zeros", cnt, 0);
    @(negedge clk);
    chk("div1_done_b", {done1, state1}, {1'b1, 2'd2});
    load1 = 1'b0;
    @(negedge clk);
    chk("div1_ready", {ready1, state1}, {1'b1, 2'd0});
    @(negedge clk);
    force dut.state_q = 2'd3;
    #1 release dut.state_q;
    #1 chk("forced_state", state, 2'd3);
    @(negedge clk);
    chk("illegal_recover", {state, ready, serial_bit}, {2'd0, 1'b1, 1'b0});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8: number of bits per word, legal range 2..32.
REQ-002 The block SHALL take parameter DIV, default 4: clock cycles per serial bit, legal range 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port data_in, input, WIDTH bits: the parallel word to serialize.
REQ-006 The block SHALL have port load, input, 1 bit: request to capture data_in.
REQ-007 The block SHALL have port ready, output, 1 bit: high when a load will be accepted.
REQ-008 The block SHALL have port serial_bit, output, 1 bit, registered: the serial stream, MSB first; it feeds the downstream 101-sequence detector's input bit.
REQ-009 The block SHALL have port bit_valid, output, 1 bit: one-cycle strobe marking the last cycle of each bit period.
REQ-010 The block SHALL have port busy, output, 1 bit: high while shifting.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last bit of a word.
REQ-012 The block SHALL have port state, output, 2 bits: current FSM state code.

Function
REQ-013 The FSM SHALL have states IDLE=2'd0, SHIFT=2'd1 and DONE=2'd2; code 2'd3 is unreachable and SHALL return to IDLE on the next edge.
REQ-014 All outputs SHALL be Moore outputs: ready=(state==IDLE), busy=(state==SHIFT), done=(state==DONE), bit_valid=(state==SHIFT && div_cnt==DIV-1).
REQ-015 In IDLE, on an edge with load=1, the block SHALL perform all of the following on that edge:
- capture data_in into the shift register;
- set serial_bit to data_in[WIDTH-1];
- clear div_cnt and bit_cnt;
- enter SHIFT.
REQ-016 In IDLE with load=0, the state SHALL stay IDLE and serial_bit SHALL be 0.
REQ-017 In SHIFT, div_cnt SHALL count 0..DIV-1, and serial_bit SHALL hold each bit for exactly DIV cycles.
REQ-018 In SHIFT, on an edge with div_cnt==DIV-1 and bit_cnt<WIDTH-1, the block SHALL shift left by one, present the next bit on serial_bit, increment bit_cnt and clear div_cnt.
REQ-019 In SHIFT, on an edge with div_cnt==DIV-1 and bit_cnt==WIDTH-1, the block SHALL enter DONE and clear serial_bit to 0.
REQ-020 DONE SHALL last exactly one cycle and SHALL then go to IDLE unconditionally; load is ignored while in DONE.
REQ-021 Load SHALL be ignored in SHIFT and in DONE; data_in changes after capture SHALL NOT affect the word in flight.
REQ-022 Latency: with load accepted at edge t, the block SHALL be in SHIFT for WIDTH*DIV cycles, done SHALL be high in the cycle after edge t+WIDTH*DIV, and ready SHALL rise one cycle later.
REQ-023 When DIV=1, bit_valid SHALL be high in every SHIFT cycle, with one bit per clock.
REQ-024 Word throughput SHALL be at most one word per WIDTH*DIV+2 cycles, and load held high continuously SHALL start a new word on every IDLE edge.
REQ-025 bit_cnt SHALL be wide enough for WIDTH-1, div_cnt wide enough for DIV-1, and neither SHALL wrap past its terminal value.

Reset
REQ-026 While rst=1, regardless of clk, the block SHALL hold state=IDLE, serial_bit=0, shift register=0, div_cnt=0 and bit_cnt=0; hence ready=1 and busy=done=bit_valid=0.
REQ-027 Reset asserted mid-SHIFT SHALL abort the word immediately, with no done pulse for the aborted word.
REQ-028 After reset deasserts, the first edge with load=1 SHALL start a fresh word.

Verification
REQ-029 The bench SHALL cover: WIDTH=8, DIV=4, load 8'hA5 -> serial_bit sequence 1,0,1,0,0,1,0,1, each held 4 cycles; 8 bit_valid pulses; done 32 cycles after accept; ready one cycle later.
REQ-030 The bench SHALL cover: load 8'hC3 during SHIFT of 8'hA5 -> ignored; output stream is still A5; no second done.
REQ-031 The bench SHALL cover: rst pulse after the 3rd bit_valid -> serial_bit=0, state=0, ready=1 asynchronously; no done; next load of 8'h0F serializes fully.
REQ-032 The bench SHALL cover: DIV=1, load held high with data 8'hFF then 8'h00 -> 8 ones, done, idle cycle, 8 zeros; bit_valid high in all 16 SHIFT cycles.
REQ-033 The bench SHALL cover: a chain to the downstream 101 detector with 8'hA8 (10101000) -> detector output high twice, once after the 3rd bit and once after the 5th bit.
REQ-034 The bench SHALL cover: forcing the state register to 2'd3 -> state 2'd0 on the next edge; ready=1.
